// File: rtl/cu_sequencer.sv
// rtl/cu_sequencer.sv - fetch/decode/execute/writeback control FSM; optional retired-instruction counter under CU_PERF_CNT_EN
module cu_sequencer #(
    parameter int unsigned FETCH_WAIT  = 1,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_rd,
    input  logic        update_flags,
    input  logic        ig_ex,
    input  logic        br_en,
    input  logic        br_link,
    input  logic        halt_req,
    output logic        wr_en,
    output logic        branch,
    output logic        cu_decode,
    output logic        cu_execute,
    output logic        ld_pc,
    output logic        ld_lr,
    output logic        ld_rd,
    output logic        ld_apsr,
    output logic        ld_sp,
    output logic        ld_ipsr,
    output logic        ld_primask,
    output logic        halted,
    output logic [2:0]  state,
    output logic [31:0] inst_count
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    localparam logic [3:0] WAIT_LOAD = 4'(FETCH_WAIT - 1);
    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [3:0] exec_cnt_q, exec_cnt_d;
    logic       write_rd_q, update_flags_q, ig_ex_q, br_en_q, br_link_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RESET;
            wait_cnt_q     <= 4'd0;
            exec_cnt_q     <= 4'd0;
            write_rd_q     <= 1'b0;
            update_flags_q <= 1'b0;
            ig_ex_q        <= 1'b0;
            br_en_q        <= 1'b0;
            br_link_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            exec_cnt_q <= exec_cnt_d;
            if (state_q == ST_DECODE) begin
                write_rd_q     <= write_rd;
                update_flags_q <= update_flags;
                ig_ex_q        <= ig_ex;
                br_en_q        <= br_en;
                br_link_q      <= br_link;
            end
        end
    end

    // Inputs only steer the next state; every output decodes from registered state.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        exec_cnt_d = exec_cnt_q;
        wr_en      = 1'b0;
        branch     = 1'b0;
        cu_decode  = 1'b0;
        cu_execute = 1'b0;
        ld_pc      = 1'b0;
        ld_lr      = 1'b0;
        ld_rd      = 1'b0;
        ld_apsr    = 1'b0;
        ld_sp      = 1'b0;
        ld_ipsr    = 1'b0;
        ld_primask = 1'b0;
        halted     = 1'b0;
        case (state_q)
            ST_RESET: begin
                state_d    = ST_FETCH;
                wait_cnt_d = WAIT_LOAD;
            end
            ST_FETCH: begin
                if (wait_cnt_q == 4'd0) state_d = ST_DECODE;
                else                    wait_cnt_d = wait_cnt_q - 4'd1;
            end
            ST_DECODE: begin
                cu_decode = 1'b1;
                if (ig_ex) begin
                    state_d = ST_WB;
                end else begin
                    state_d    = ST_EXEC;
                    exec_cnt_d = EXEC_LOAD;
                end
            end
            ST_EXEC: begin
                cu_execute = 1'b1;
                if (exec_cnt_q == 4'd0) state_d = ST_WB;
                else                    exec_cnt_d = exec_cnt_q - 4'd1;
            end
            ST_WB: begin
                ld_pc   = 1'b1;
                ld_rd   = write_rd_q & ~ig_ex_q;
                ld_apsr = update_flags_q & ~ig_ex_q;
                branch  = br_en_q & ~ig_ex_q;
                ld_lr   = br_en_q & br_link_q & ~ig_ex_q;
                if (halt_req) begin
                    state_d = ST_HALT;
                end else begin
                    state_d    = ST_FETCH;
                    wait_cnt_d = WAIT_LOAD;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
                if (!halt_req) begin
                    state_d    = ST_FETCH;
                    wait_cnt_d = WAIT_LOAD;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    assign state = state_q;

`ifdef CU_PERF_CNT_EN
    logic [31:0] inst_count_q;

    // Skipped instructions retire through WB too, so they are counted.
    always_ff @(posedge clk) begin
        if (rst)                    inst_count_q <= 32'd0;
        else if (state_q == ST_WB)  inst_count_q <= inst_count_q + 32'd1;
    end

    assign inst_count = inst_count_q;
`else
    assign inst_count = 32'h0;
`endif

endmodule

// File: tb/tb_cu_sequencer.sv
// tb/tb_cu_sequencer.sv - self-checking bench for cu_sequencer (default and FETCH_WAIT=3/EXEC_CYCLES=2 instances)
module tb_cu_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, write_rd, update_flags, ig_ex, br_en, br_link, halt_req;

    // {wr_en, branch, cu_decode, cu_execute, ld_pc, ld_lr, ld_rd, ld_apsr, ld_sp, ld_ipsr, ld_primask, halted, state}
    wire [14:0] a_out, b_out;
    wire [31:0] a_cnt, b_cnt;

    cu_sequencer dut_a (
        .clk(clk), .rst(rst), .write_rd(write_rd), .update_flags(update_flags),
        .ig_ex(ig_ex), .br_en(br_en), .br_link(br_link), .halt_req(halt_req),
        .wr_en(a_out[14]), .branch(a_out[13]), .cu_decode(a_out[12]), .cu_execute(a_out[11]),
        .ld_pc(a_out[10]), .ld_lr(a_out[9]), .ld_rd(a_out[8]), .ld_apsr(a_out[7]),
        .ld_sp(a_out[6]), .ld_ipsr(a_out[5]), .ld_primask(a_out[4]), .halted(a_out[3]),
        .state(a_out[2:0]), .inst_count(a_cnt)
    );

    cu_sequencer #(.FETCH_WAIT(3), .EXEC_CYCLES(2)) dut_b (
        .clk(clk), .rst(rst), .write_rd(write_rd), .update_flags(update_flags),
        .ig_ex(ig_ex), .br_en(br_en), .br_link(br_link), .halt_req(halt_req),
        .wr_en(b_out[14]), .branch(b_out[13]), .cu_decode(b_out[12]), .cu_execute(b_out[11]),
        .ld_pc(b_out[10]), .ld_lr(b_out[9]), .ld_rd(b_out[8]), .ld_apsr(b_out[7]),
        .ld_sp(b_out[6]), .ld_ipsr(b_out[5]), .ld_primask(b_out[4]), .halted(b_out[3]),
        .state(b_out[2:0]), .inst_count(b_cnt)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference: each instruction expands into a queue of per-cycle expected output words.
    logic [14:0] qa[$];
    logic [14:0] qb[$];
    int unsigned cnt[2];
    logic [14:0] last_a, last_b;
    logic [31:0] last_a_cnt;

    function automatic logic [14:0] mk(input logic [2:0] st, input bit dec, exe, pc, lr, rd, ap, br, hl);
        return {1'b0, br, dec, exe, pc, lr, rd, ap, 3'b000, hl, st};
    endfunction

    function automatic void push(input int m, input logic [14:0] v);
        if (m == 0) qa.push_back(v);
        else        qb.push_back(v);
    endfunction

    function automatic logic [14:0] pop(input int m);
        if (m == 0) return (qa.size() == 0) ? 15'h7fff : qa.pop_front();
        return (qb.size() == 0) ? 15'h7fff : qb.pop_front();
    endfunction

    function automatic logic [31:0] exp_cnt(input int m);
`ifdef CU_PERF_CNT_EN
        return cnt[m];
`else
        return (m < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    function automatic void chk15(input string nm, input logic [14:0] act, input logic [14:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void plan_instr(input int m, input int fw);
        for (int i = 0; i < fw; i++) push(m, mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0));
        push(m, mk(3'd2, 1, 0, 0, 0, 0, 0, 0, 0));
    endfunction

    function automatic void model_step(input int m, input bit r, wr, uf, ig, be, bl, hr, input logic [14:0] cur);
        int fw, ec;
        fw = (m == 0) ? 1 : 3;
        ec = (m == 0) ? 1 : 2;
        if (r) begin
            if (m == 0) qa.delete();
            else        qb.delete();
            push(m, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
            cnt[m] = 0;
            return;
        end
        if (cur[2:0] == 3'd4) cnt[m]++;
        case (cur[2:0])
            3'd0: plan_instr(m, fw);
            3'd2: begin
                if (!ig) for (int i = 0; i < ec; i++) push(m, mk(3'd3, 0, 1, 0, 0, 0, 0, 0, 0));
                push(m, mk(3'd4, 0, 0, 1, be & bl & !ig, wr & !ig, uf & !ig, be & !ig, 0));
            end
            3'd4, 3'd5: begin
                if (hr) push(m, mk(3'd5, 0, 0, 0, 0, 0, 0, 0, 1));
                else    plan_instr(m, fw);
            end
            default: ;
        endcase
    endfunction

    task automatic cycle(input bit r, wr, uf, ig, be, bl, hr);
        logic [14:0] ea, eb;
        rst = r; write_rd = wr; update_flags = uf; ig_ex = ig; br_en = be; br_link = bl; halt_req = hr;
        @(negedge clk);
        ea = pop(0);
        eb = pop(1);
        last_a = a_out;
        last_b = b_out;
        last_a_cnt = a_cnt;
        chk15("model_a", a_out, ea);
        chk15("model_b", b_out, eb);
        chk32("count_a", a_cnt, exp_cnt(0));
        chk32("count_b", b_cnt, exp_cnt(1));
        model_step(0, r, wr, uf, ig, be, bl, hr, ea);
        model_step(1, r, wr, uf, ig, be, bl, hr, eb);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          wr, uf, ig, be, bl;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[17];

    initial begin
        bit found;
        int prev_wb, exec_run, halted_n, wb_n;

        tbl[0]  = '{0, 0, 0, 0, 0, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{0, 0, 0, 0, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{0, 0, 0, 0, 0, mk(3'd2, 1, 0, 0, 0, 0, 0, 0, 0)};
        tbl[3]  = '{0, 0, 0, 0, 0, mk(3'd3, 0, 1, 0, 0, 0, 0, 0, 0)};
        tbl[4]  = '{0, 0, 0, 0, 0, mk(3'd4, 0, 0, 1, 0, 0, 0, 0, 0)};
        tbl[5]  = '{0, 0, 0, 0, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[6]  = '{1, 1, 0, 0, 0, mk(3'd2, 1, 0, 0, 0, 0, 0, 0, 0)};
        tbl[7]  = '{0, 0, 0, 0, 0, mk(3'd3, 0, 1, 0, 0, 0, 0, 0, 0)};
        tbl[8]  = '{0, 0, 0, 0, 0, mk(3'd4, 0, 0, 1, 0, 1, 1, 0, 0)};
        tbl[9]  = '{0, 0, 0, 0, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[10] = '{1, 0, 1, 1, 0, mk(3'd2, 1, 0, 0, 0, 0, 0, 0, 0)};
        tbl[11] = '{0, 0, 0, 0, 0, mk(3'd4, 0, 0, 1, 0, 0, 0, 0, 0)};
        tbl[12] = '{0, 0, 0, 0, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[13] = '{0, 0, 0, 1, 1, mk(3'd2, 1, 0, 0, 0, 0, 0, 0, 0)};
        tbl[14] = '{0, 0, 0, 0, 0, mk(3'd3, 0, 1, 0, 0, 0, 0, 0, 0)};
        tbl[15] = '{0, 0, 0, 0, 0, mk(3'd4, 0, 0, 1, 1, 0, 0, 1, 0)};
        tbl[16] = '{0, 0, 0, 0, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0)};

        rst = 1'b1; write_rd = 0; update_flags = 0; ig_ex = 0; br_en = 0; br_link = 0; halt_req = 0;
        cnt[0] = 0; cnt[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        qa.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        qb.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        cycle(1, 0, 0, 0, 0, 0, 0);
        chk15("reset_outputs", last_a, 15'h0);
        chk32("reset_count", last_a_cnt, 32'd0);

        // Release, plain, write_rd/flags, skipped, branch-link on the default instance.
        for (int i = 0; i < 17; i++) begin
            cycle(0, tbl[i].wr, tbl[i].uf, tbl[i].ig, tbl[i].be, tbl[i].bl, 0);
            chk15($sformatf("table_%0d", i), last_a, tbl[i].exp);
        end

        // BL on FETCH_WAIT=3/EXEC_CYCLES=2: 2 execute cycles, period 7.
        cycle(1, 0, 0, 0, 0, 0, 0);
        prev_wb = -1; exec_run = 0;
        for (int i = 1; i <= 23; i++) begin
            cycle(0, 1, 0, 0, 1, 1, 0);
            if (last_b[11]) exec_run++;
            if (last_b[10]) begin
                if (prev_wb >= 0) chk32("bl_period", 32'(i - prev_wb), 32'd7);
                chk32("bl_exec_cycles", 32'(exec_run), 32'd2);
                chk15("bl_wb", last_b & 15'h3787, mk(3'd4, 0, 0, 1, 1, 1, 0, 1, 0));
                exec_run = 0;
                prev_wb = i;
            end
        end

        // Halt raised in EXEC and held 10 cycles.
        cycle(1, 0, 0, 0, 0, 0, 0);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 0);
            if (last_a[2:0] == 3'd2) begin found = 1; break; end
        end
        chk32("halt_reach_decode", 32'(found), 32'd1);
        halted_n = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 1);
            if (i == 1) chk15("halt_wb_completes", last_a, mk(3'd4, 0, 0, 1, 0, 0, 0, 0, 0));
            if (last_a[3]) halted_n++;
        end
        found = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 0);
            if (last_a[2:0] == 3'd1) begin found = 1; break; end
            if (last_a[3]) halted_n++;
        end
        chk32("halt_resume_fetch", 32'(found), 32'd1);
        chk32("halted_cycles", 32'(halted_n), 32'd9);

        // Reset mid-EXEC after 5 retired instructions.
        cycle(1, 0, 0, 0, 0, 0, 0);
        wb_n = 0; found = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 0);
            if (last_a[10]) wb_n++;
            if (wb_n == 5 && last_a[2:0] == 3'd2) begin found = 1; break; end
        end
        chk32("rst_reach_decode", 32'(found), 32'd1);
        cycle(1, 0, 0, 0, 0, 0, 0);
        chk15("rst_in_exec", last_a, mk(3'd3, 0, 1, 0, 0, 0, 0, 0, 0));
`ifdef CU_PERF_CNT_EN
        chk32("count_before_rst", last_a_cnt, 32'd5);
`else
        chk32("count_before_rst", last_a_cnt, 32'd0);
`endif
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk15("rst_outputs_zero", last_a, 15'h0);
        chk32("rst_count_zero", last_a_cnt, 32'd0);

        // Random traffic against the reference.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 59) == 0, 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                  1'($urandom), 1'($urandom), $urandom_range(0, 6) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
